// File: rtl/qed_pkg.sv
// qed_pkg: shared constants for the QED instruction monitor.
//   - RV32 opcode / funct3 / funct7 encodings used by the legality decode
//   - the NOP opcode reserved for the QED harness
//   - FSM state typedef for the monitor
package qed_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b1111111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_ORIG = 2'd0,
        ST_DUP  = 2'd1,
        ST_ERR  = 2'd2
    } qed_state_e;

endpackage

// File: rtl/qed_inst_decode.sv
// qed_inst_decode: combinational legality check of one RV32 instruction word.
// Ports:
//   instruction : candidate instruction word
//   inst_legal  : 1 when the word is in the allowed QED instruction subset
//   is_nop      : 1 when the word carries the harness NOP opcode
module qed_inst_decode
    import qed_pkg::*;
#(
    parameter int REG_HALF      = 16,
    parameter int EN_MUL        = 1,
    parameter int EN_MEM        = 1,
    parameter int MEM_ZERO_BITS = 2
) (
    input  logic [31:0] instruction,
    output logic        inst_legal,
    output logic        is_nop
);

    localparam logic [5:0]  REG_LIM  = 6'(REG_HALF);
    // Top MEM_ZERO_BITS bits of the word; empty mask when the parameter is 0.
    localparam logic [31:0] MEM_MASK = ~(32'hFFFF_FFFF >> MEM_ZERO_BITS);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_ok;
    logic       rs1_ok;
    logic       rs2_ok;
    logic       mem_hi_ok;

    always_comb begin
        opcode    = instruction[6:0];
        rd        = instruction[11:7];
        funct3    = instruction[14:12];
        rs1       = instruction[19:15];
        rs2       = instruction[24:20];
        funct7    = instruction[31:25];
        rd_ok     = {1'b0, rd}  < REG_LIM;
        rs1_ok    = {1'b0, rs1} < REG_LIM;
        rs2_ok    = {1'b0, rs2} < REG_LIM;
        mem_hi_ok = (instruction & MEM_MASK) == 32'd0;
        is_nop    = opcode == OP_NOP;
        inst_legal = 1'b0;
        unique case (opcode)
            OP_IMM: begin
                // Shift-immediates reuse the top imm bits as funct7.
                if (funct3 == F3_SLL)
                    inst_legal = funct7 == F7_BASE;
                else if (funct3 == F3_SR)
                    inst_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else
                    inst_legal = 1'b1;
                inst_legal = inst_legal && rd_ok && rs1_ok;
            end
            OP_REG: begin
                inst_legal = ((funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))) ||
                              ((EN_MUL != 0) && (funct7 == F7_MULDIV) && !funct3[2]))
                             && rd_ok && rs1_ok && rs2_ok;
            end
            OP_LOAD: begin
                inst_legal = (EN_MEM != 0) && (funct3 == F3_WORD) && (rs1 == 5'd0)
                             && rd_ok && mem_hi_ok;
            end
            OP_STORE: begin
                inst_legal = (EN_MEM != 0) && (funct3 == F3_WORD) && (rs1 == 5'd0)
                             && rs2_ok && mem_hi_ok;
            end
            OP_NOP:  inst_legal = 1'b1;
            default: inst_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/qed_inst_monitor.sv
// qed_inst_monitor: QED original/duplicate stream monitor.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   instruction : candidate instruction word
//   inst_valid  : instruction issued this cycle
//   exec_dup    : duplicate phase requested
//   inst_legal  : combinational legality of instruction
//   orig_cnt    : original-phase non-NOP issue count (saturating)
//   dup_cnt     : duplicate-phase non-NOP issue count (saturating)
//   qed_ready   : registered, streams balanced and fault-free
//   err         : [0] illegal issue, [1] protocol fault (sticky)
module qed_inst_monitor
    import qed_pkg::*;
#(
    parameter int REG_HALF      = 16,
    parameter int EN_MUL        = 1,
    parameter int EN_MEM        = 1,
    parameter int MEM_ZERO_BITS = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    input  logic             exec_dup,
    output logic             inst_legal,
    output logic [CNT_W-1:0] orig_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic             qed_ready,
    output logic [1:0]       err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    qed_state_e       state_q, state_d;
    logic [CNT_W-1:0] orig_cnt_q, orig_cnt_d;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [1:0]       err_q, err_d;
    logic             qed_ready_q, qed_ready_d;

    logic is_nop;
    logic illegal;
    logic counted;
    logic dup_phase;
    logic dup_drop;
    logic overrun;
    logic sat_hit;

    qed_inst_decode #(
        .REG_HALF      (REG_HALF),
        .EN_MUL        (EN_MUL),
        .EN_MEM        (EN_MEM),
        .MEM_ZERO_BITS (MEM_ZERO_BITS)
    ) u_decode (
        .instruction (instruction),
        .inst_legal  (inst_legal),
        .is_nop      (is_nop)
    );

    // State register and all tracked state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ORIG;
            orig_cnt_q  <= '0;
            dup_cnt_q   <= '0;
            err_q       <= 2'b00;
            qed_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            orig_cnt_q  <= orig_cnt_d;
            dup_cnt_q   <= dup_cnt_d;
            err_q       <= err_d;
            qed_ready_q <= qed_ready_d;
        end
    end

    // Event classification. Phase follows exec_dup while in ORIG so an
    // instruction issued alongside the first exec_dup lands in dup_cnt.
    always_comb begin
        illegal   = inst_valid && !inst_legal;
        counted   = inst_valid && inst_legal && !is_nop;
        dup_phase = (state_q == ST_DUP) || ((state_q == ST_ORIG) && exec_dup);
        dup_drop  = (state_q == ST_DUP) && !exec_dup;
        overrun   = counted && dup_phase && (dup_cnt_q >= orig_cnt_q);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ORIG: begin
                if (illegal || overrun) state_d = ST_ERR;
                else if (exec_dup)      state_d = ST_DUP;
            end
            ST_DUP: begin
                if (illegal || overrun || dup_drop) state_d = ST_ERR;
            end
            default: state_d = ST_ERR;
        endcase
    end

    // Counters, sticky flags and the ready flag.
    always_comb begin
        orig_cnt_d = orig_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        sat_hit    = 1'b0;
        if ((state_q != ST_ERR) && counted) begin
            // An overrunning duplicate still counts; only saturation blocks it.
            if (dup_phase) begin
                if (dup_cnt_q == CNT_MAX) sat_hit = 1'b1;
                else                      dup_cnt_d = dup_cnt_q + CNT_ONE;
            end else begin
                if (orig_cnt_q == CNT_MAX) sat_hit = 1'b1;
                else                       orig_cnt_d = orig_cnt_q + CNT_ONE;
            end
        end
        err_d = err_q | {dup_drop || overrun || sat_hit, illegal};
        // Ready only if this cycle neither faults nor leaves DUP, so it is
        // never seen high while the FSM sits in ERR.
        qed_ready_d = (state_q == ST_DUP) && (state_d == ST_DUP)
                      && (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0)
                      && (err_d == 2'b00);
    end

    assign orig_cnt  = orig_cnt_q;
    assign dup_cnt   = dup_cnt_q;
    assign err       = err_q;
    assign qed_ready = qed_ready_q;

endmodule
